// File: rtl/rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decode_arbiter
//
// Round-robin arbiter that shares the 3-to-8 decoder output stage among
// eight requesters. One owner at a time gets a one-hot grant plus its
// binary index, which drives the decoder select. The grant is held until
// the owner strobes DONE, withdraws its request, EN drops, or (optionally)
// the hold timer expires. Every release is followed by exactly one RELEASE
// cycle with GNT=0, and the released owner becomes lowest priority.
//
// Optional feature: define ARB_TIMEOUT_EN to build the hold counter.
// A grant is then force-released after HOLD_MAX cycles, and TIMEOUT
// pulses for the one RELEASE cycle that follows. Without the macro no
// counter exists and TIMEOUT is a constant 0.
//
// Ports:
//   CLK      in   1  system clock, rising edge
//   RST      in   1  asynchronous, active-high reset
//   EN       in   1  enable; low blocks new grants and releases the owner
//   REQ      in   8  level-sensitive requests
//   DONE     in   1  owner's one-cycle completion strobe
//   GNT      out  8  one-hot grant, zero when nobody owns the resource
//   GNT_IDX  out  3  index of the current or most recent owner
//   BUSY     out  1  high while a grant is held
//   TIMEOUT  out  1  one-cycle pulse on forced release
//
// Parameter:
//   HOLD_MAX  maximum grant length in cycles (2..255), timeout build only
// ---------------------------------------------------------------------------
module rr_decode_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] REQ,
  input  logic       DONE,
  output logic [7:0] GNT,
  output logic [2:0] GNT_IDX,
  output logic       BUSY,
  output logic       TIMEOUT
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_decode_arbiter: HOLD_MAX must be in 2..255");
  end

  logic [1:0] state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [2:0] last_q, last_d;

  logic       grant_now;
  logic       hold_expired;

  // Rotate REQ so that bit 0 of rot_req is requester (LAST+1) mod 8.
  // A plain lowest-set-bit search on rot_req is then the round-robin pick.
  logic [7:0] rot_req;
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_rot
    logic [2:0] src_idx;
    assign src_idx     = last_q + 3'(gi + 1);
    assign rot_req[gi] = REQ[src_idx];
  end

  logic [2:0] win_off;
  logic       win_found;
  logic [2:0] win_idx;

  always_comb begin
    win_off   = 3'd0;
    win_found = 1'b0;
    // Descending loop so the lowest set bit wins the last assignment.
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) begin
        win_off   = 3'(i);
        win_found = 1'b1;
      end
    end
  end

  // Undo the rotation: offset 0 corresponds to requester LAST+1.
  assign win_idx = last_q + win_off + 3'd1;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;

  // DONE on the final allowed cycle is an ordinary release, not a timeout.
  assign hold_expired = (hold_cnt_q == 8'(HOLD_MAX - 1)) && !DONE;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (grant_now) begin
      hold_cnt_d = 8'd0;
    end else if (state_q == ST_GRANT) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    grant_now = 1'b0;

    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        if (EN && win_found) begin
          state_d   = ST_GRANT;
          gnt_d     = 8'b1 << win_idx;
          gnt_idx_d = win_idx;
          busy_d    = 1'b1;
          grant_now = 1'b1;
        end else begin
          // GNT_IDX keeps the most recent owner for the decoder select.
          state_d = ST_IDLE;
          gnt_d   = 8'h00;
          busy_d  = 1'b0;
        end
      end
      ST_GRANT: begin
        // Only the owner's own REQ bit matters while granted.
        if (DONE || !REQ[gnt_idx_q] || !EN || hold_expired) begin
          state_d   = ST_RELEASE;
          gnt_d     = 8'h00;
          busy_d    = 1'b0;
          last_d    = gnt_idx_q;
          timeout_d = hold_expired;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 8'h00;
      gnt_idx_q <= 3'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 3'd7;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
    end
  end

  assign GNT     = gnt_q;
  assign GNT_IDX = gnt_idx_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;

endmodule
